// File: rtl/aes_key_schedule_seq.sv
// Word-serial AES-128/192/256 key schedule producing one 32-bit word per cycle
// and streaming 128-bit round keys, optionally buffered for reverse replay.
module aes_key_schedule_seq #(
  parameter int unsigned BUF_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic         rev,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         rk_last,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_DRAIN, S_FIN} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254) followed by the AES affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x3, x7, x15, x31, x63, x127, b;
    x3   = gf_mul(gf_mul(x, x), x);
    x7   = gf_mul(gf_mul(x3, x3), x);
    x15  = gf_mul(gf_mul(x7, x7), x);
    x31  = gf_mul(gf_mul(x15, x15), x);
    x63  = gf_mul(gf_mul(x31, x31), x);
    x127 = gf_mul(gf_mul(x63, x63), x);
    b    = gf_mul(x127, x127);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_t         state, state_nxt;
  logic [255:0]   key_q;
  logic [1:0]     klen_q;
  logic           rev_q;
  logic [5:0]     wcnt;
  logic [2:0]     kcnt;
  logic [7:0]     rcon;
  logic [31:0]    win [0:7];
  logic           rk_valid_q, rk_last_q, err_q;
  logic [127:0]   rk_data_q;
  logic [3:0]     rk_idx_q;

  logic [3:0]     nk, nr;
  logic [2:0]     back_idx;
  logic [5:0]     total;
  logic           gen_active, rk_complete, hs, out_free, advance, last_word, start_ok;
  logic [7:0]     key_msb;
  logic [31:0]    key_word, t, new_word;
  logic [127:0]   new_rk, buf_rd_data;
  logic [3:0]     rd_idx;

  always_comb begin
    nk       = 4'd4;
    nr       = 4'd10;
    back_idx = 3'd4;
    total    = 6'd44;
    case (klen_q)
      2'b01: begin nk = 4'd6; nr = 4'd12; back_idx = 3'd2; total = 6'd52; end
      2'b10: begin nk = 4'd8; nr = 4'd14; back_idx = 3'd0; total = 6'd60; end
      default: ;
    endcase
  end

  assign start_ok    = (state == S_IDLE) && start && (key_len != 2'b11);
  assign gen_active  = (state == S_GEN) && (wcnt < total);
  assign rk_complete = gen_active && (wcnt[1:0] == 2'b11);
  assign hs          = rk_valid_q && rk_ready;
  assign out_free    = !rk_valid_q || rk_ready;
  // Forward runs stall on a completed key the sink has not made room for
  assign advance     = gen_active && (!rk_complete || rev_q || out_free);
  assign last_word   = (wcnt == total - 6'd1);
  assign rd_idx      = rk_idx_q - 4'd1;

  assign key_msb  = 8'd255 - {wcnt[2:0], 5'b00000};
  assign key_word = key_q[key_msb -: 32];

  always_comb begin
    t = win[7];
    if (kcnt == 3'd0)
      t = sub_word({win[7][23:0], win[7][31:24]}) ^ {rcon, 24'h000000};
    else if ((nk == 4'd8) && (kcnt == 3'd4))
      t = sub_word(win[7]);
    new_word = (wcnt < {2'b00, nk}) ? key_word : (win[back_idx] ^ t);
    new_rk   = {win[5], win[6], win[7], new_word};
  end

  generate
    if (BUF_EN != 0) begin : g_buf
      logic [127:0] rk_buf [0:14];
      logic [14:0]  buf_vld;

      always_ff @(posedge clk) begin
        if (advance && rk_complete) rk_buf[wcnt[5:2]] <= new_rk;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          buf_vld <= '0;
        else if (start_ok)
          buf_vld <= '0;
        else if (advance && rk_complete)
          buf_vld[wcnt[5:2]] <= 1'b1;
      end

      assign buf_rd_data = buf_vld[rd_idx] ? rk_buf[rd_idx] : '0;
    end else begin : g_nobuf
      assign buf_rd_data = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    done      = (state == S_FIN);
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_GEN;
      S_GEN: begin
        if (hs && rk_last_q)                       state_nxt = S_FIN;
        else if (rev_q && advance && last_word)    state_nxt = S_DRAIN;
      end
      S_DRAIN: if (hs && rk_last_q) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q      <= '0;
      klen_q     <= 2'b00;
      rev_q      <= 1'b0;
      wcnt       <= '0;
      kcnt       <= '0;
      rcon       <= 8'h01;
      for (int j = 0; j < 8; j++) win[j] <= '0;
      rk_valid_q <= 1'b0;
      rk_last_q  <= 1'b0;
      rk_data_q  <= '0;
      rk_idx_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= (state == S_IDLE) && start && (key_len == 2'b11);
      if (start_ok) begin
        key_q  <= key_in;
        klen_q <= key_len;
        rev_q  <= (BUF_EN != 0) ? rev : 1'b0;
        wcnt   <= '0;
        kcnt   <= '0;
        rcon   <= 8'h01;
      end
      if (advance) begin
        for (int j = 0; j < 7; j++) win[j] <= win[j+1];
        win[7] <= new_word;
        wcnt   <= wcnt + 6'd1;
        kcnt   <= (kcnt == nk[2:0] - 3'd1) ? 3'd0 : kcnt + 3'd1;
        if ((wcnt >= {2'b00, nk}) && (kcnt == 3'd0)) rcon <= xtime(rcon);
      end
      if (hs) rk_valid_q <= 1'b0;
      // Reverse runs only present the final key directly; the rest comes from the buffer
      if (advance && rk_complete && (!rev_q || last_word)) begin
        rk_valid_q <= 1'b1;
        rk_data_q  <= new_rk;
        rk_idx_q   <= wcnt[5:2];
        rk_last_q  <= !rev_q && (wcnt[5:2] == nr);
      end
      if ((state == S_DRAIN) && hs && (rk_idx_q != 4'd0)) begin
        rk_valid_q <= 1'b1;
        rk_data_q  <= buf_rd_data;
        rk_idx_q   <= rd_idx;
        rk_last_q  <= (rk_idx_q == 4'd1);
      end
    end
  end

  assign rk_valid = rk_valid_q;
  assign rk_data  = rk_data_q;
  assign rk_idx   = rk_idx_q;
  assign rk_last  = rk_last_q;
  assign err      = err_q;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed bench for aes_key_schedule_seq using FIPS-197 key expansion vectors.
module tb_aes_key_schedule_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   key_len;
  logic         rev;
  logic [255:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         rk_last;
  logic         done;
  logic         err;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic [127:0] exp128 [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

  logic [127:0] exp256 [0:14] = '{
    128'h603deb1015ca71be2b73aef0857d7781, 128'h1f352c073b6108d72d9810a30914dff4,
    128'h9ba354118e6925afa51a8b5f2067fcde, 128'ha8b09c1a93d194cdbe49846eb75d5b9a,
    128'hd59aecb85bf3c917fee94248de8ebe96, 128'hb5a9328a2678a647983122292f6c79b3,
    128'h812c81addadf48ba24360af2fab8b464, 128'h98c5bfc9bebd198e268c3ba709e04214,
    128'h68007bacb2df331696e939e46c518d80, 128'hc814e20476a9fb8a5025c02d59c58239,
    128'hde1369676ccc5a71fa2563959674ee15, 128'h5886ca5d2e2f31d77e0af1fa27cf73c3,
    128'h749c47ab18501ddae2757e4f7401905a, 128'hcafaaae3e4d59b349adf6acebd10190d,
    128'hfe4890d1e6188d0b046df344706c631e};

  always #5 clk = ~clk;

  aes_key_schedule_seq #(.BUF_EN(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_len  (key_len),
    .rev      (rev),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_data  (rk_data),
    .rk_idx   (rk_idx),
    .rk_last  (rk_last),
    .done     (done),
    .err      (err)
  );

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Inputs are scrambled after the start cycle so only captured values matter
  task automatic applyStimulus(input logic [1:0] kl, input logic rv, input logic [255:0] key);
    @(negedge clk);
    start   = 1'b1;
    key_len = kl;
    rev     = rv;
    key_in  = key;
    @(negedge clk);
    start   = 1'b0;
    key_len = 2'b11;
    rev     = ~rv;
    key_in  = ~key;
  endtask

  task automatic getKey(input bit stall, input int exp_idx, input logic [127:0] exp_data,
                        input bit chk_data, input string tag, output logic lst, output int waited);
    bit got;
    got    = 1'b0;
    waited = 0;
    lst    = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      waited++;
      rk_ready = stall ? ($urandom_range(0, 99) >= 30) : 1'b1;
      if (rk_valid) begin
        checkOutput($sformatf("%s_idx%0d", tag, exp_idx), 128'(rk_idx), 128'(exp_idx));
        if (chk_data) checkOutput($sformatf("%s_rk%0d", tag, exp_idx), rk_data, exp_data);
        if (rk_ready) begin
          got = 1'b1;
          lst = rk_last;
        end
      end
    end
    checkOutput($sformatf("%s_handshake%0d", tag, exp_idx), 128'(got), 128'(1));
  endtask

  task automatic checkDone(input string tag);
    @(negedge clk);
    checkOutput({tag, "_done"}, 128'(done), 128'(1));
    checkOutput({tag, "_valid_after"}, 128'(rk_valid), 128'(0));
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 128'(done), 128'(0));
    checkOutput({tag, "_idle"}, 128'(busy), 128'(0));
  endtask

  task automatic run128(input string tag);
    logic lst;
    int   waited;
    applyStimulus(2'b00, 1'b0, K128);
    checkOutput({tag, "_busy"}, 128'(busy), 128'(1));
    for (int r = 0; r <= 10; r++) begin
      getKey(1'b0, r, exp128[r], 1'b1, tag, lst, waited);
      checkOutput($sformatf("%s_last%0d", tag, r), 128'(lst), 128'(r == 10));
      checkOutput($sformatf("%s_wait%0d", tag, r), 128'(waited), 128'(4));
    end
    checkDone(tag);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic lst;
    int   waited;
    rst_n = 1'b0; start = 1'b0; key_len = 2'b00; rev = 1'b0; key_in = '0; rk_ready = 1'b0;
    #12;
    checkOutput("reset_busy", 128'(busy), 128'(0));
    checkOutput("reset_valid", 128'(rk_valid), 128'(0));
    checkOutput("reset_done", 128'(done), 128'(0));
    checkOutput("reset_err", 128'(err), 128'(0));
    checkOutput("reset_data", rk_data, 128'(0));
    checkOutput("reset_idx", 128'(rk_idx), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] AES-128 forward");
    run128("a128");

    $display("[TB] AES-192 forward");
    applyStimulus(2'b01, 1'b0, K192);
    for (int r = 0; r <= 12; r++) begin
      getKey(1'b0, r, (r == 0) ? 128'h8e73b0f7da0e6452c810f32b809079e5 : 128'he98ba06f448c773c8ecc720401002202,
             (r == 0) || (r == 12), "a192", lst, waited);
      checkOutput($sformatf("a192_last%0d", r), 128'(lst), 128'(r == 12));
    end
    checkDone("a192");

    $display("[TB] AES-256 reverse");
    applyStimulus(2'b10, 1'b1, K256);
    for (int r = 14; r >= 0; r--) begin
      getKey(1'b0, r, exp256[r], 1'b1, "r256", lst, waited);
      checkOutput($sformatf("r256_last%0d", r), 128'(lst), 128'(r == 0));
      checkOutput($sformatf("r256_wait%0d", r), 128'(waited), (r == 14) ? 128'(60) : 128'(1));
    end
    checkDone("r256");

    $display("[TB] AES-256 forward with random stalls");
    applyStimulus(2'b10, 1'b0, K256);
    for (int r = 0; r <= 14; r++) begin
      getKey(1'b1, r, exp256[r], 1'b1, "s256", lst, waited);
      checkOutput($sformatf("s256_last%0d", r), 128'(lst), 128'(r == 14));
    end
    rk_ready = 1'b1;
    checkDone("s256");

    $display("[TB] illegal key length");
    applyStimulus(2'b11, 1'b0, K128);
    checkOutput("illegal_err", 128'(err), 128'(1));
    checkOutput("illegal_busy", 128'(busy), 128'(0));
    @(negedge clk);
    checkOutput("illegal_err_pulse", 128'(err), 128'(0));
    checkOutput("illegal_still_idle", 128'(busy), 128'(0));

    $display("[TB] start while busy");
    applyStimulus(2'b00, 1'b0, K128);
    for (int r = 0; r <= 10; r++) begin
      getKey(1'b0, r, exp128[r], 1'b1, "busy128", lst, waited);
      checkOutput($sformatf("busy128_last%0d", r), 128'(lst), 128'(r == 10));
      if (r == 2) begin
        @(negedge clk);
        start = 1'b1; key_len = 2'b10; rev = 1'b1; key_in = K256;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_start_no_err", 128'(err), 128'(0));
      end
    end
    checkDone("busy128");

    $display("[TB] reset during AES-256 run");
    applyStimulus(2'b10, 1'b0, K256);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_valid", 128'(rk_valid), 128'(0));
    checkOutput("midreset_busy", 128'(busy), 128'(0));
    checkOutput("midreset_data", rk_data, 128'(0));
    checkOutput("midreset_idx", 128'(rk_idx), 128'(0));
    checkOutput("midreset_done", 128'(done), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run128("post128");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
